sensor_request_scheduler: RTL

SENSOR_REQUEST_SCHEDULER -- requirements
Module: sensor_request_scheduler

---
 rtl/sensor_request_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sensor_request_scheduler.sv
// Queues UART sensor requests and serves them one at a time in arrival order; SCHED_TIMEOUT_EN adds a WAIT timeout.
// Latency: push to tx_start is 4 clocks minimum with an empty queue and a sensor that answers at once.
// Backpressure: requests arriving while the queue is full are dropped (sticky overflow); tx_busy holds SEND.
module sensor_request_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned NUM_SENSORS    = 1,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_command,
  input  logic [7:0] rx_address,
  output logic       sensor_enable,
  output logic [7:0] sensor_command,
  output logic [7:0] sensor_address,
  input  logic       sensor_done,
  input  logic [7:0] sensor_resp_command,
  input  logic [7:0] sensor_resp_value,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_command,
  output logic [7:0] tx_value,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND,
    S_RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   q_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    head_addr, head_cmd;
  logic          push, pop, head_in_range;
  logic          capture, load_ef, load_to, fire_tx, timeout_hit;

  // Occupancy is sampled before any same-cycle pop, so a full queue drops even if IDLE pops.
  assign push          = rx_valid && (count < DEPTH);
  assign fifo_full     = (count == DEPTH);
  assign {head_addr, head_cmd} = q_mem[rd_ptr];
  assign head_in_range = (32'(head_addr) < NUM_SENSORS);
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (push) q_mem[wr_ptr] <= {rx_address, rx_command};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (rx_valid && !push) overflow <= 1'b1;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [23:0] wait_cnt;

  assign timeout_hit = (wait_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (state == S_ISSUE) wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 24'd1;
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    load_ef   = 1'b0;
    load_to   = 1'b0;
    fire_tx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_in_range) begin
            state_nxt = S_ISSUE;
          end else begin
            load_ef   = 1'b1;
            state_nxt = S_SEND;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (sensor_done) begin
          capture   = 1'b1;
          state_nxt = S_SEND;
        end else if (timeout_hit) begin
          load_to   = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          fire_tx   = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!sensor_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request bytes stay latched from the pop until the next pop, covering ISSUE through RELEASE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sensor_enable  <= 1'b0;
      sensor_command <= 8'h00;
      sensor_address <= 8'h00;
      tx_start       <= 1'b0;
      tx_command     <= 8'h00;
      tx_value       <= 8'h00;
    end else begin
      tx_start <= fire_tx;
      if (pop) begin
        sensor_command <= head_cmd;
        sensor_address <= head_addr;
      end
      if (pop && head_in_range) sensor_enable <= 1'b1;
      else if (fire_tx)         sensor_enable <= 1'b0;
      if (load_ef)      {tx_command, tx_value} <= 16'hEFEF;
      else if (load_to) {tx_command, tx_value} <= 16'h1F1F;
      else if (capture) {tx_command, tx_value} <= {sensor_resp_command, sensor_resp_value};
    end
  end

endmodule
